// File: rtl/cam_ctrl.sv
// cam_ctrl: sequencing/arbitration controller in front of a CAM datapath.
// Shares the CAM between a write requester (append) and a lookup requester
// (search by content). Owns entry allocation (write pointer, valid bits,
// occupancy, full/empty, clear). Turns the CAM match vector into a masked
// lowest-index result with hit and multi-hit flags.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ena               gates new grants only
//   clr               level; invalidates all entries while idle
//   wr_valid/ready    write request handshake, wr_data = content to store
//   lk_valid/ready    lookup request handshake, lk_data = search key
//   lk_resp_valid     one-cycle result strobe; lk_hit/lk_multi/lk_idx held
//   count/full/empty  occupancy status
//   cam_we/waddr      registered CAM write strobe and address
//   cam_content       registered CAM write data or search key
//   cam_found         CAM match vector, valid the cycle after key is presented
module cam_ctrl #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [WIDTH-1:0] lk_data,
  output logic             lk_resp_valid,
  output logic             lk_hit,
  output logic             lk_multi,
  output logic [AW-1:0]    lk_idx,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             cam_we,
  output logic [AW-1:0]    cam_waddr,
  output logic [WIDTH-1:0] cam_content,
  input  logic [DEPTH-1:0] cam_found
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR       = 2'd1,
    S_LK_ISSUE = 2'd2,
    S_LK_WAIT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_rr_last_lk;

  logic             r_cam_we;
  logic [AW-1:0]    r_cam_waddr;
  logic [WIDTH-1:0] r_cam_content;

  logic             r_lk_resp_valid;
  logic             r_lk_hit;
  logic             r_lk_multi;
  logic [AW-1:0]    r_lk_idx;

  logic             w_full;
  logic             w_wr_elig;
  logic             w_grant_wr;
  logic             w_grant_lk;
  logic             w_wr_ready;
  logic             w_lk_ready;
  logic             w_clr_do;

  logic [DEPTH-1:0] w_match;
  logic [AW:0]      w_nmatch;
  logic [AW-1:0]    w_low_idx;
  logic             w_seen;

  // Round-robin arbitration; a full CAM makes write ineligible so lookup wins
  assign w_full     = (r_count == CNT_FULL);
  assign w_wr_elig  = wr_valid & ~w_full;
  assign w_grant_wr = w_wr_elig & (~lk_valid | r_rr_last_lk);
  assign w_grant_lk = lk_valid & (~w_wr_elig | ~r_rr_last_lk);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake decode; readies and clear only exist in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b0;
    w_lk_ready  = 1'b0;
    w_clr_do    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clr_do   = clr;
        w_wr_ready = ena & ~clr & w_grant_wr;
        w_lk_ready = ena & ~clr & w_grant_lk;
        if (w_wr_ready)      w_state_nxt = S_WR;
        else if (w_lk_ready) w_state_nxt = S_LK_ISSUE;
      end
      S_WR:       w_state_nxt = S_IDLE;
      S_LK_ISSUE: w_state_nxt = S_LK_WAIT;
      S_LK_WAIT:  w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Mask CAM matches with valid bits, then find popcount and lowest index
  always_comb begin
    w_match   = cam_found & r_valid;
    w_nmatch  = '0;
    w_low_idx = '0;
    w_seen    = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_match[i]) begin
        w_nmatch = w_nmatch + (AW+1)'(1);
        if (!w_seen) begin
          w_low_idx = AW'(i);
          w_seen    = 1'b1;
        end
      end
    end
  end

  // Allocation, CAM drive and lookup result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid         <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_rr_last_lk    <= 1'b1;
      r_cam_we        <= 1'b0;
      r_cam_waddr     <= '0;
      r_cam_content   <= '0;
      r_lk_resp_valid <= 1'b0;
      r_lk_hit        <= 1'b0;
      r_lk_multi      <= 1'b0;
      r_lk_idx        <= '0;
    end else begin
      r_lk_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_clr_do) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
          end else if (w_wr_ready) begin
            r_cam_content <= wr_data;
            r_cam_waddr   <= r_wr_ptr;
            r_cam_we      <= 1'b1;
            r_rr_last_lk  <= 1'b0;
          end else if (w_lk_ready) begin
            r_cam_content <= lk_data;
            r_rr_last_lk  <= 1'b1;
          end
        end
        // Entry becomes valid as the write strobe ends, before any later lookup
        S_WR: begin
          r_valid[r_wr_ptr] <= 1'b1;
          r_wr_ptr          <= r_wr_ptr + AW'(1);
          r_count           <= r_count + (AW+1)'(1);
          r_cam_we          <= 1'b0;
        end
        S_LK_WAIT: begin
          r_lk_hit        <= w_seen;
          r_lk_multi      <= (w_nmatch > (AW+1)'(1));
          r_lk_idx        <= w_low_idx;
          r_lk_resp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_ready      = w_wr_ready;
  assign lk_ready      = w_lk_ready;
  assign lk_resp_valid = r_lk_resp_valid;
  assign lk_hit        = r_lk_hit;
  assign lk_multi      = r_lk_multi;
  assign lk_idx        = r_lk_idx;
  assign count         = r_count;
  assign full          = w_full;
  assign empty         = (r_count == '0);
  assign cam_we        = r_cam_we;
  assign cam_waddr     = r_cam_waddr;
  assign cam_content   = r_cam_content;

endmodule

// File: tb/tb_cam_ctrl.sv
// Testbench for cam_ctrl: a behavioural CAM stub plus an entry-list model.
module tb_cam_ctrl;
  localparam int unsigned WIDTH = 7;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n, ena, clr;
  logic             wr_valid, wr_ready, lk_valid, lk_ready;
  logic [WIDTH-1:0] wr_data, lk_data;
  logic             lk_resp_valid, lk_hit, lk_multi;
  logic [AW-1:0]    lk_idx;
  logic [AW:0]      count;
  logic             full, empty, cam_we;
  logic [AW-1:0]    cam_waddr;
  logic [WIDTH-1:0] cam_content;
  logic [DEPTH-1:0] cam_found = '0;

  always #5 clk = ~clk;

  cam_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_data(lk_data),
    .lk_resp_valid(lk_resp_valid), .lk_hit(lk_hit), .lk_multi(lk_multi),
    .lk_idx(lk_idx), .count(count), .full(full), .empty(empty),
    .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_content(cam_content),
    .cam_found(cam_found)
  );

  // CAM stub: stores every write, never forgets (stale entries survive clr)
  logic [WIDTH-1:0] cam_mem [DEPTH];
  logic [DEPTH-1:0] cam_wr      = '0;
  logic             stub_ovr_en = 1'b0;
  logic [DEPTH-1:0] stub_ovr    = '0;

  function automatic logic [DEPTH-1:0] stub_match(input logic [WIDTH-1:0] key);
    logic [DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DEPTH); i++) v[i] = cam_wr[i] && (cam_mem[i] == key);
    return v;
  endfunction

  always @(posedge clk) begin
    if (cam_we) begin
      cam_mem[cam_waddr] <= cam_content;
      cam_wr[cam_waddr]  <= 1'b1;
    end
    cam_found <= stub_ovr_en ? stub_ovr : stub_match(cam_content);
  end

  // Reference model: ordered list of live entries
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               ref_cnt = 0;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected result: live entries matching (or flagged by the override vector)
  task automatic expect_lookup(input logic [WIDTH-1:0] key, input logic ovr_en,
                               input logic [DEPTH-1:0] ovr, output logic hit,
                               output logic multi, output logic [AW-1:0] idx);
    int n;
    n = 0;
    idx = '0;
    for (int i = 0; i < ref_cnt; i++) begin
      if (ovr_en ? ovr[i] : (ref_mem[i] == key)) begin
        if (n == 0) idx = AW'(i);
        n++;
      end
    end
    hit   = (n > 0);
    multi = (n > 1);
  endtask

  function automatic logic [WIDTH-1:0] pick_word();
    case ($urandom_range(0, 3))
      0:       return 7'h15;
      1:       return 7'h2A;
      2:       return 7'h7F;
      default: return WIDTH'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic wait_ready(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (is_wr ? wr_ready : lk_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(is_wr ? "wr_ready_wait" : "lk_ready_wait", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0;
    wr_valid = 1'b0; lk_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_cnt = 0;
  endtask

  task automatic do_write(input logic [WIDTH-1:0] data);
    bit ok;
    wr_data = data; wr_valid = 1'b1;
    wait_ready(1'b1, ok);
    @(negedge clk);
    wr_valid = 1'b0;
    if (!ok) return;
    check("wr_cam_we", 32'(cam_we), 32'd1);
    check("wr_cam_waddr", 32'(cam_waddr), 32'(ref_cnt));
    check("wr_cam_content", 32'(cam_content), 32'(data));
    ref_mem[ref_cnt] = data;
    ref_cnt++;
    @(negedge clk);
    check("wr_cam_we_off", 32'(cam_we), 32'd0);
    check("wr_count", 32'(count), 32'(ref_cnt));
    check("wr_empty", 32'(empty), 32'(ref_cnt == 0));
    check("wr_full", 32'(full), 32'(ref_cnt == int'(DEPTH)));
  endtask

  task automatic do_lookup(input logic [WIDTH-1:0] key, input logic ovr_en,
                           input logic [DEPTH-1:0] ovr);
    bit ok;
    logic e_hit, e_multi;
    logic [AW-1:0] e_idx;
    stub_ovr_en = ovr_en; stub_ovr = ovr;
    lk_data = key; lk_valid = 1'b1;
    wait_ready(1'b0, ok);
    expect_lookup(key, ovr_en, ovr, e_hit, e_multi, e_idx);
    @(negedge clk);
    lk_valid = 1'b0;
    if (ok) begin
      check("lk_resp_early1", 32'(lk_resp_valid), 32'd0);
      check("lk_cam_key", 32'(cam_content), 32'(key));
      check("lk_cam_we", 32'(cam_we), 32'd0);
      @(negedge clk);
      check("lk_resp_early2", 32'(lk_resp_valid), 32'd0);
      @(negedge clk);
      check("lk_resp_valid", 32'(lk_resp_valid), 32'd1);
      check("lk_hit", 32'(lk_hit), 32'(e_hit));
      check("lk_multi", 32'(lk_multi), 32'(e_multi));
      check("lk_idx", 32'(lk_idx), 32'(e_idx));
      @(negedge clk);
      check("lk_resp_pulse", 32'(lk_resp_valid), 32'd0);
      check("lk_hit_hold", 32'(lk_hit), 32'(e_hit));
    end
    stub_ovr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ref_cnt = 0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_full", 32'(full), 32'd0);
  endtask

  initial begin
    bit ok;
    bit exp_w;
    int grants;
    int op;
    logic e_hit, e_multi;
    logic [AW-1:0] e_idx;

    rst_n = 1'b0; ena = 1'b1; clr = 1'b0;
    wr_valid = 1'b0; lk_valid = 1'b0; wr_data = '0; lk_data = '0;
    @(negedge clk);
    do_reset();

    // Reset values
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_cam_we", 32'(cam_we), 32'd0);
    check("rst_cam_waddr", 32'(cam_waddr), 32'd0);
    check("rst_cam_content", 32'(cam_content), 32'd0);
    check("rst_resp", 32'(lk_resp_valid), 32'd0);
    check("rst_hit", 32'(lk_hit), 32'd0);
    check("rst_multi", 32'(lk_multi), 32'd0);
    check("rst_idx", 32'(lk_idx), 32'd0);
    check("rst_ready", 32'({wr_ready, lk_ready}), 32'd0);
    @(negedge clk);

    // Directed writes and multi-hit lookup
    do_write(7'h15);
    do_write(7'h2A);
    do_write(7'h15);
    do_lookup(7'h15, 1'b1, 16'h0005);
    do_lookup(7'h2A, 1'b0, '0);
    do_lookup(7'h15, 1'b0, '0);

    // Lookup on empty CAM: match vector fully masked
    do_reset();
    do_lookup(7'h7F, 1'b1, 16'hFFFF);

    // ena low freezes grants
    ena = 1'b0; wr_valid = 1'b1; lk_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ena_low_ready", 32'({wr_ready, lk_ready}), 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b0; lk_valid = 1'b0; ena = 1'b1;
    @(negedge clk);
    check("ena_low_count", 32'(count), 32'd0);

    // Round-robin alternation with both requesters held high
    do_reset();
    wr_data = 7'h33; lk_data = 7'h33;
    wr_valid = 1'b1; lk_valid = 1'b1;
    exp_w = 1'b1; grants = 0;
    for (int k = 0; k < 60 && grants < 8; k++) begin
      #1;
      if (wr_ready || lk_ready) begin
        check("arb_wr_grant", 32'(wr_ready), 32'(exp_w));
        check("arb_lk_grant", 32'(lk_ready), 32'(!exp_w));
        if (wr_ready) begin
          ref_mem[ref_cnt] = wr_data;
          ref_cnt++;
        end
        exp_w = !exp_w;
        grants++;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0; lk_valid = 1'b0;
    check("arb_grants", 32'(grants), 32'd8);
    repeat (4) @(negedge clk);
    check("arb_count", 32'(count), 32'(ref_cnt));

    // Randomized mix of writes, lookups and clears
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3 && ref_cnt < int'(DEPTH)) do_write(pick_word());
      else if (op <= 7)                     do_lookup(pick_word(), 1'b0, '0);
      else if (op == 8)                     do_lookup(pick_word(), 1'b1, DEPTH'($urandom));
      else                                  do_clr();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Fill to full; write blocked, lookup still served; clr restarts at 0
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) do_write(WIDTH'($urandom_range(0, 127)));
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'(DEPTH));
    wr_valid = 1'b1; wr_data = 7'h01;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("full_wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
    end
    do_lookup(ref_mem[5], 1'b0, '0);
    wr_valid = 1'b0;
    do_clr();
    do_write(7'h15);

    // clr during LK_ISSUE: pre-clear result delivered, clear applied after
    do_write(7'h2A);
    do_write(7'h15);
    lk_data = 7'h15; lk_valid = 1'b1;
    wait_ready(1'b0, ok);
    expect_lookup(7'h15, 1'b0, '0, e_hit, e_multi, e_idx);
    @(negedge clk);
    lk_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    check("clrmid_count_wait", 32'(count), 32'(ref_cnt));
    @(negedge clk);
    check("clrmid_resp", 32'(lk_resp_valid), 32'd1);
    check("clrmid_hit", 32'(lk_hit), 32'(e_hit));
    check("clrmid_multi", 32'(lk_multi), 32'(e_multi));
    check("clrmid_idx", 32'(lk_idx), 32'(e_idx));
    check("clrmid_count_resp", 32'(count), 32'(ref_cnt));
    @(negedge clk);
    clr = 1'b0; ref_cnt = 0;
    check("clrmid_count_after", 32'(count), 32'd0);
    check("clrmid_empty_after", 32'(empty), 32'd1);

    // Reset during LK_WAIT drops the pending response
    do_write(7'h44);
    lk_data = 7'h44; lk_valid = 1'b1;
    wait_ready(1'b0, ok);
    @(negedge clk);
    lk_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rstmid_resp", 32'(lk_resp_valid), 32'd0);
      check("rstmid_hit", 32'(lk_hit), 32'd0);
      check("rstmid_idx", 32'(lk_idx), 32'd0);
      check("rstmid_count", 32'(count), 32'd0);
      check("rstmid_empty", 32'(empty), 32'd1);
      check("rstmid_cam_we", 32'(cam_we), 32'd0);
      check("rstmid_cam_content", 32'(cam_content), 32'd0);
    end
    rst_n = 1'b1; ref_cnt = 0;
    @(negedge clk);
    check("rstmid_resp_after", 32'(lk_resp_valid), 32'd0);
    do_write(7'h0C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
